seq_multiply: RTL and testbench

SEQ_MULTIPLY -- requirements
Module: seq_multiply

---
 rtl/seq_mult_pkg.sv | 13 +
 rtl/seq_mult_if.sv | 31 +++
 rtl/seq_mult_dp.sv | 58 +++++
 rtl/seq_multiply.sv | 84 ++++++++
 tb/tb_seq_multiply.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package seq_mult_pkg;

  localparam int DEFAULT_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/seq_mult_if.sv
// Request/result bundle for seq_multiply; is_signed exists only when SEQ_MULT_SIGNED_EN is defined.
// start is a level request sampled only while the FSM is idle; finished is a one-cycle result-valid pulse.
interface seq_mult_if #(
  parameter int WIDTH = 12
);
  logic                 start;
  logic [WIDTH-1:0]     multiplier;
  logic [WIDTH-1:0]     multiplicand;
`ifdef SEQ_MULT_SIGNED_EN
  logic                 is_signed;
`endif
  logic [2*WIDTH-1:0]   product;
  logic                 busy;
  logic                 finished;

  modport master (
`ifdef SEQ_MULT_SIGNED_EN
    output is_signed,
`endif
    output start, multiplier, multiplicand,
    input  product, busy, finished
  );

  modport slave (
`ifdef SEQ_MULT_SIGNED_EN
    input  is_signed,
`endif
    input  start, multiplier, multiplicand,
    output product, busy, finished
  );
endinterface

// File: rtl/seq_mult_dp.sv
// Multiplier datapath: product register, (W+1)-bit adder/subtractor and right-shift logic,
// driven by load/step/last strobes from the controlling FSM.
module seq_mult_dp #(
  parameter int WIDTH = 12
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               last_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic               signed_i,
  output logic [2*WIDTH-1:0] product_o
);

  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic               sgn_q, sgn_d;
  logic [WIDTH:0]     hi_ext;
  logic [WIDTH:0]     a_ext;
  logic [WIDTH:0]     sum;

  // In signed mode the top bit of both adder operands is the sign; otherwise zero.
  // The multiplicand MSB carries negative weight, so the final step subtracts.
  always_comb begin
    hi_ext = {sgn_q & prod_q[2*WIDTH-1], prod_q[2*WIDTH-1:WIDTH]};
    a_ext  = {sgn_q & mplr_q[WIDTH-1], mplr_q};
    sum    = (last_i && sgn_q) ? (hi_ext - a_ext) : (hi_ext + a_ext);

    prod_d = prod_q;
    mplr_d = mplr_q;
    sgn_d  = sgn_q;
    if (load_i) begin
      prod_d = {{WIDTH{1'b0}}, multiplicand_i};
      mplr_d = multiplier_i;
      sgn_d  = signed_i;
    end else if (step_i) begin
      if (prod_q[0]) prod_d = {sum, prod_q[WIDTH-1:1]};
      else           prod_d = {hi_ext, prod_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prod_q <= '0;
      mplr_q <= '0;
      sgn_q  <= 1'b0;
    end else begin
      prod_q <= prod_d;
      mplr_q <= mplr_d;
      sgn_q  <= sgn_d;
    end
  end

  assign product_o = prod_q;

endmodule

// File: rtl/seq_multiply.sv
// Sequential multiplier top: IDLE/RUN/DONE/HOLD controller around seq_mult_dp.
// Define SEQ_MULT_SIGNED_EN to add the is_signed two's-complement mode.
module seq_multiply
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic   clock,
  input  logic   reset,
  seq_mult_if.slave bus,
  output state_e state_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, step, last;
  logic             signed_in;
  logic             cnt_end;

`ifdef SEQ_MULT_SIGNED_EN
  assign signed_in = bus.is_signed;
`else
  assign signed_in = 1'b0;
`endif

  assign cnt_end = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_end) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = bus.start ? HOLD : IDLE;
      // A start still held after completion must drop before another request is seen.
      HOLD: if (!bus.start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  seq_mult_dp #(.WIDTH(WIDTH)) u_dp (
    .clock          (clock),
    .reset          (reset),
    .load_i         (load),
    .step_i         (step),
    .last_i         (last),
    .multiplier_i   (bus.multiplier),
    .multiplicand_i (bus.multiplicand),
    .signed_i       (signed_in),
    .product_o      (bus.product)
  );

  assign bus.busy     = (state_q == RUN);
  assign bus.finished = (state_q == DONE);
  assign state_o      = state_q;

endmodule

// File: tb/tb_seq_multiply.sv
// Directed bench for seq_multiply: WIDTH=12 and WIDTH=4 instances with hand-computed products.
module tb_seq_multiply;
  import seq_mult_pkg::*;

  logic   clock;
  logic   reset;
  state_e st12, st4;
  int     total = 0;
  int     bad   = 0;

  seq_mult_if #(.WIDTH(12)) m12 ();
  seq_mult_if #(.WIDTH(4))  m4 ();

  seq_multiply #(.WIDTH(12)) dut12 (.clock(clock), .reset(reset), .bus(m12), .state_o(st12));
  seq_multiply #(.WIDTH(4))  dut4  (.clock(clock), .reset(reset), .bus(m4),  .state_o(st4));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Accept edge is cycle 0; operands are scrambled afterwards to show they are ignored.
  task automatic run_op(input string tag, input logic [11:0] a, input logic [11:0] b,
                        input logic sgn, input logic [23:0] exp);
    @(negedge clock);
    m12.start        = 1'b1;
    m12.multiplier   = a;
    m12.multiplicand = b;
`ifdef SEQ_MULT_SIGNED_EN
    m12.is_signed    = sgn;
`endif
    @(posedge clock);
    #1;
    m12.start        = 1'b0;
    m12.multiplier   = 12'($urandom_range(0, 4095));
    m12.multiplicand = 12'($urandom_range(0, 4095));
`ifdef SEQ_MULT_SIGNED_EN
    m12.is_signed    = ~sgn;
`endif
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      check({tag, "_busy"}, 64'(m12.busy), 64'(k <= 12));
      check({tag, "_fin"},  64'(m12.finished), 64'(k == 13));
      if (k >= 13) check({tag, "_prod"}, 64'(m12.product), 64'(exp));
    end
    if (sgn) begin end
  endtask

  int fin_cnt;
  int busy_cnt;

  initial begin
    reset = 1'b1;
    m12.start = 1'b0; m12.multiplier = '0; m12.multiplicand = '0;
    m4.start  = 1'b0; m4.multiplier  = '0; m4.multiplicand  = '0;
`ifdef SEQ_MULT_SIGNED_EN
    m12.is_signed = 1'b0;
    m4.is_signed  = 1'b0;
`endif
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_prod",  64'(m12.product), 64'd0);
    check("rst_busy",  64'(m12.busy), 64'd0);
    check("rst_fin",   64'(m12.finished), 64'd0);
    check("rst_state", 64'(st12), 64'(IDLE));
    check("rst_prod4", 64'(m4.product), 64'd0);
    reset = 1'b0;

    run_op("max",   12'd4095, 12'd4095, 1'b0, 24'hFFE001);
    run_op("zero_a", 12'd0,   12'd2748, 1'b0, 24'd0);
    run_op("zero_b", 12'd2748, 12'd0,   1'b0, 24'd0);
    run_op("mix",   12'd1234, 12'd567,  1'b0, 24'd699678);
    run_op("pow2",  12'd2048, 12'd2,    1'b0, 24'd4096);
    run_op("one",   12'd1,    12'd1,    1'b0, 24'd1);

`ifdef SEQ_MULT_SIGNED_EN
    run_op("s_m1m1",   12'hFFF, 12'hFFF, 1'b1, 24'd1);
    run_op("s_minmax", 12'h800, 12'h7FF, 1'b1, 24'hC00800);
    run_op("s_minmin", 12'h800, 12'h800, 1'b1, 24'h400000);
    run_op("s_off",    12'hFFF, 12'hFFF, 1'b0, 24'hFFE001);
`endif

    // Held start: one operation only, FSM parks in HOLD.
    @(negedge clock);
    m12.start = 1'b1; m12.multiplier = 12'd5; m12.multiplicand = 12'd7;
    fin_cnt = 0; busy_cnt = 0;
    @(posedge clock);
    #1;
    m12.multiplier = 12'd3; m12.multiplicand = 12'd3;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      fin_cnt  += int'(m12.finished);
      busy_cnt += int'(m12.busy);
    end
    check("hold_fin_cnt",  64'(fin_cnt), 64'd1);
    check("hold_busy_cnt", 64'(busy_cnt), 64'd12);
    check("hold_state",    64'(st12), 64'(HOLD));
    check("hold_prod",     64'(m12.product), 64'd35);
    m12.start = 1'b0;
    @(negedge clock);
    check("hold_release", 64'(st12), 64'(IDLE));
    run_op("after_hold", 12'd9, 12'd11, 1'b0, 24'd99);

    // Reset in the sixth RUN cycle discards the operation.
    @(negedge clock);
    m12.start = 1'b1; m12.multiplier = 12'd4095; m12.multiplicand = 12'd4095;
    @(posedge clock);
    #1;
    m12.start = 1'b0;
    for (int k = 1; k <= 6; k++) @(negedge clock);
    check("pre_rst_busy", 64'(m12.busy), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_busy",  64'(m12.busy), 64'd0);
    check("mid_rst_fin",   64'(m12.finished), 64'd0);
    check("mid_rst_prod",  64'(m12.product), 64'd0);
    check("mid_rst_state", 64'(st12), 64'(IDLE));
    reset = 1'b0;
    run_op("after_rst", 12'd100, 12'd200, 1'b0, 24'd20000);

    // WIDTH=4 instance: finished in cycle 5.
    for (int t = 0; t < 2; t++) begin
      @(negedge clock);
      m4.start        = 1'b1;
      m4.multiplier   = (t == 0) ? 4'd15 : 4'd3;
      m4.multiplicand = (t == 0) ? 4'd15 : 4'd5;
      @(posedge clock);
      #1;
      m4.start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clock);
        check("w4_busy", 64'(m4.busy), 64'(k <= 4));
        check("w4_fin",  64'(m4.finished), 64'(k == 5));
        if (k >= 5) check("w4_prod", 64'(m4.product), (t == 0) ? 64'hE1 : 64'd15);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
